upsampler: RTL and testbench

CIC interpolation-path rate expander. Takes one signed sample per input transfer and emits CIC_R output samples: the sample itself followed by CIC_R-1 fill samples, which are zeros by default. It sits between the comb section and the integrator section of the CIC interpolator, the mirror of the decimator's downsampler. Both sides use AXI-Stream-style valid/ready handshakes, so the integrators or the DAC path can apply backpressure.

---
 rtl/upsampler.sv | 121 ++++++++++++
 tb/tb_upsampler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsampler.sv
// upsampler: CIC interpolation rate expander.
// Each accepted input sample is emitted once, followed by CIC_R-1 fill samples,
// using valid/ready handshakes on both sides so downstream stages can stall.
// Build option: define UPSAMPLER_HOLD_EN for zero-order hold (fill samples
// repeat the accepted sample). Without it, fill samples are zero (zero-stuffing).
module upsampler #(
    parameter int DATA_WIDTH_INP = 8,
    parameter int CIC_R          = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic signed [DATA_WIDTH_INP-1:0] s_axis_in_tdata,
    input  logic                             s_axis_in_tvalid,
    output logic                             s_axis_in_tready,
    output logic signed [DATA_WIDTH_INP-1:0] m_axis_out_tdata,
    output logic                             m_axis_out_tvalid,
    input  logic                             m_axis_out_tready,
    output logic                             m_axis_out_tlast
);

    localparam int PHASE_W = (CIC_R > 1) ? $clog2(CIC_R) : 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE   = PHASE_W'(CIC_R - 1);
    localparam logic [PHASE_W-1:0] PENULT_PHASE = PHASE_W'(CIC_R - 2);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                             state_p0;
    state_t                             state_nxt;
    logic        [PHASE_W-1:0]          phase_p0;
    logic                               last_p0;
    logic signed [DATA_WIDTH_INP-1:0]   data_p0;
    logic signed [DATA_WIDTH_INP-1:0]   fill_val;
    logic                               vld_p0;
    logic                               fire_in;
    logic                               fire_out;
    logic                               at_last_phase;

    assign at_last_phase = (phase_p0 == LAST_PHASE);
    assign fire_in       = s_axis_in_tvalid & s_axis_in_tready;
    assign fire_out      = vld_p0 & m_axis_out_tready;

    // State register: IDLE while the output register is empty, EMIT while it holds a phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // Next state: a new sample always wins; the group ends when its last phase is taken.
    always_comb begin
        state_nxt = state_p0;
        if (fire_in) begin
            state_nxt = EMIT;
        end else if (fire_out && at_last_phase) begin
            state_nxt = IDLE;
        end
    end

    // Outputs of the FSM: valid follows the state, ready opens only when the
    // output register is empty or its last phase is leaving this cycle.
    always_comb begin
        vld_p0           = (state_p0 == EMIT);
        s_axis_in_tready = !reset && ((state_p0 == IDLE) ||
                                      (m_axis_out_tready && at_last_phase));
    end

    // Phase counter and last-phase flag, advanced on every accepted output.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_p0 <= '0;
            last_p0  <= 1'b0;
        end else if (fire_in) begin
            phase_p0 <= '0;
            last_p0  <= 1'b0;
        end else if (fire_out) begin
            if (!at_last_phase) begin
                phase_p0 <= phase_p0 + 1'b1;
                last_p0  <= (phase_p0 == PENULT_PHASE);
            end else begin
                phase_p0 <= '0;
                last_p0  <= 1'b0;
            end
        end
    end

    // Output data register: new sample on accept, fill value on each later phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_p0 <= '0;
        end else if (fire_in) begin
            data_p0 <= s_axis_in_tdata;
        end else if (fire_out && !at_last_phase) begin
            data_p0 <= fill_val;
        end
    end

`ifdef UPSAMPLER_HOLD_EN
    logic signed [DATA_WIDTH_INP-1:0] hold_p0;

    // Held copy of the accepted sample, so fill phases never depend on data_p0.
    always_ff @(posedge clk) begin
        if (fire_in) begin
            hold_p0 <= s_axis_in_tdata;
        end
    end

    assign fill_val = hold_p0;
`else
    assign fill_val = '0;
`endif

    assign m_axis_out_tdata  = data_p0;
    assign m_axis_out_tvalid = vld_p0;
    assign m_axis_out_tlast  = last_p0;

endmodule

// File: tb/tb_upsampler.sv
// tb_upsampler: bench for upsampler (CIC_R=4 and CIC_R=2 instances, width 8).
// Honours UPSAMPLER_HOLD_EN when computing fill values.
module tb_upsampler;

    localparam int W = 8;
`ifdef UPSAMPLER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct packed {
        logic signed [W-1:0] din;
        logic [3:0][W-1:0]   exp;
    } vec_t;

    typedef struct {
        int data;
        bit last;
        int ph;
    } sb_t;

    logic clk = 1'b0;
    logic reset;

    logic signed [W-1:0] s_tdata, m_tdata;
    logic s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;

    logic signed [W-1:0] s2_tdata, m2_tdata;
    logic s2_tvalid, s2_tready, m2_tvalid, m2_tready, m2_tlast;

    int   errors = 0;
    int   checks = 0;
    sb_t  sb[$];
    vec_t cur_exp;
    bit   acc;
    bit   prev_vld;
    int   rises;
    int   vld_cycles;
    vec_t tbl[8];

    always #5 clk = ~clk;

    upsampler #(.DATA_WIDTH_INP(W), .CIC_R(4)) u4 (
        .clk(clk), .reset(reset),
        .s_axis_in_tdata(s_tdata), .s_axis_in_tvalid(s_tvalid), .s_axis_in_tready(s_tready),
        .m_axis_out_tdata(m_tdata), .m_axis_out_tvalid(m_tvalid),
        .m_axis_out_tready(m_tready), .m_axis_out_tlast(m_tlast)
    );

    upsampler #(.DATA_WIDTH_INP(W), .CIC_R(2)) u2 (
        .clk(clk), .reset(reset),
        .s_axis_in_tdata(s2_tdata), .s_axis_in_tvalid(s2_tvalid), .s_axis_in_tready(s2_tready),
        .m_axis_out_tdata(m2_tdata), .m_axis_out_tvalid(m2_tvalid),
        .m_axis_out_tready(m2_tready), .m_axis_out_tlast(m2_tlast)
    );

    function automatic int fill(input int d);
        return HOLD ? d : 0;
    endfunction

    function automatic vec_t mk(input logic signed [W-1:0] d);
        vec_t v;
        v.din    = d;
        v.exp[0] = d;
        for (int i = 1; i < 4; i++) v.exp[i] = W'(fill(int'(d)));
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the CIC_R=4 instance: checks handshake timing,
    // pops expected outputs on each output transfer, pushes a group on each input transfer.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_s_tready", s_tready, 0);
            sb.delete();
            prev_vld = 1'b0;
        end else begin
            if (m_tvalid && !prev_vld) rises++;
            prev_vld = m_tvalid;
            if (m_tvalid) vld_cycles++;
            chk("m_tvalid", m_tvalid, (sb.size() != 0) ? 1 : 0);
            chk("s_tready", s_tready,
                (sb.size() == 0) ? 1 : ((m_tready && sb[0].ph == 3) ? 1 : 0));
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0d expected none", m_tdata);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("out_data", m_tdata, e.data);
                    chk("out_last", m_tlast, e.last ? 1 : 0);
                end
            end
            if (s_tvalid && s_tready) begin
                for (int i = 0; i < 4; i++) begin
                    sb_t e;
                    e.data = int'($signed(cur_exp.exp[i]));
                    e.last = (i == 3);
                    e.ph   = i;
                    sb.push_back(e);
                end
                acc = 1'b1;
            end
        end
    end

    task automatic send(input vec_t v, input bit keep);
        bit ok;
        ok       = 1'b0;
        acc      = 1'b0;
        cur_exp  = v;
        s_tdata  = v.din;
        s_tvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        #1;
        if (!keep) s_tvalid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !m_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = mk(8'sd5);
        tbl[1] = mk(-8'sd3);
        tbl[2] = mk(8'sd7);
        tbl[3] = mk(-8'sd128);
        tbl[4] = mk(8'sd9);
        tbl[5] = mk(8'sd11);
        tbl[6] = mk(8'sd4);
        tbl[7] = mk(-8'sd1);

        reset = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
        s2_tvalid = 1'b0; s2_tdata = '0; m2_tready = 1'b1;
        rises = 0; vld_cycles = 0; prev_vld = 1'b0; acc = 1'b0;
        cur_exp = tbl[0];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_ready_held", s_tready, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", s_tready, 1);

        // Single sample, then idle
        send(tbl[0], 1'b0);
        drain();
        chk("single_rises", rises, 1);
        chk("single_vld_cycles", vld_cycles, 4);

        // Continuous stream, no gaps
        rises = 0; vld_cycles = 0;
        for (int i = 1; i <= 3; i++) send(tbl[i], (i != 3));
        drain();
        chk("stream_rises", rises, 1);
        chk("stream_vld_cycles", vld_cycles, 12);

        // Backpressure during phase 1
        send(tbl[4], 1'b0);
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_data", m_tdata, fill(9));
            chk("stall_vld", m_tvalid, 1);
            chk("stall_last", m_tlast, 0);
            chk("stall_rdy", s_tready, 0);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        drain();

        // Reset during phase 2 of a group
        send(tbl[5], 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tvalid", m_tvalid, 0);
        chk("midrst_tdata", m_tdata, 0);
        chk("midrst_tlast", m_tlast, 0);
        reset = 1'b0;
        #1;
        chk("midrst_ready", s_tready, 1);
        rises = 0; vld_cycles = 0;
        send(tbl[6], 1'b0);
        drain();
        chk("fresh_vld_cycles", vld_cycles, 4);

        // Hold/zero behaviour with back-to-back -1, 6
        send(tbl[7], 1'b1);
        send(mk(8'sd6), 1'b0);
        drain();

        // CIC_R=2: 100 then back-to-back 55 accepted on the last-phase cycle
        @(posedge clk);
        #1;
        s2_tvalid = 1'b1;
        s2_tdata  = 8'sd100;
        @(negedge clk);
        chk("r2_rdy_idle", s2_tready, 1);
        @(posedge clk);
        #1;
        s2_tdata = 8'sd55;
        @(negedge clk);
        chk("r2_p0_data", m2_tdata, 100);
        chk("r2_p0_vld", m2_tvalid, 1);
        chk("r2_p0_last", m2_tlast, 0);
        chk("r2_p0_rdy", s2_tready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("r2_p1_data", m2_tdata, fill(100));
        chk("r2_p1_last", m2_tlast, 1);
        chk("r2_p1_rdy", s2_tready, 1);
        @(posedge clk);
        #1;
        s2_tvalid = 1'b0;
        @(negedge clk);
        chk("r2_b2b_data", m2_tdata, 55);
        chk("r2_b2b_vld", m2_tvalid, 1);
        chk("r2_b2b_last", m2_tlast, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("r2_b2b_fill", m2_tdata, fill(55));
        chk("r2_b2b_flast", m2_tlast, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("r2_end_vld", m2_tvalid, 0);
        chk("r2_end_rdy", s2_tready, 1);

        chk("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
